// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared states, opcodes and encodings for mc_control_unit
package ctrl_pkg;

  typedef enum logic [4:0] {
    FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE,
    J_EXE, J_WB, JL_EXE, JL_WB, S_EXE, S_MEM,
    L_EXE, L_MEM, L_WB, M_EXE, M_WB, TRAP
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] RFWD_ALU    = 3'b000;
  localparam logic [2:0] RFWD_LOAD   = 3'b001;
  localparam logic [2:0] RFWD_IMM    = 3'b010;
  localparam logic [2:0] RFWD_PC_IMM = 3'b011;
  localparam logic [2:0] RFWD_PC4    = 3'b100;
  localparam logic [2:0] RFWD_MDU    = 3'b101;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } trap_cause_e;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_B, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR,
    CLS_STORE, CLS_LOAD, CLS_MDU, CLS_ILLEGAL
  } instr_class_e;

  // instr[30] only qualifies the operation for R-type and the I-type shift-right group
  function automatic logic [3:0] alu_code(input logic b30, input logic [2:0] f3,
                                          input logic use_b30);
    return {use_b30 & b30, f3};
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// rtl/ctrl_decoder.sv - combinational opcode/funct decode into instruction class and ALU code
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_e cls,
  output logic [3:0]   alu_code_o,
  output logic         illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    cls        = CLS_ILLEGAL;
    alu_code_o = ALU_ADD;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_MULDIV) begin
`ifdef RV32M_MDU_EN
          cls = CLS_MDU;
`else
          cls = CLS_ILLEGAL;
`endif
        end else begin
          cls        = CLS_R;
          alu_code_o = alu_code(instr[30], funct3, 1'b1);
        end
      end
      OP_I: begin
        cls        = CLS_I;
        alu_code_o = alu_code(instr[30], funct3, funct3 == 3'b101);
      end
      OP_BRANCH: begin
        cls        = CLS_B;
        alu_code_o = alu_code(instr[30], funct3, 1'b0);
      end
      OP_LUI:   cls = CLS_LUI;
      OP_AUIPC: cls = CLS_AUIPC;
      OP_JAL:   cls = CLS_JAL;
      OP_JALR:  cls = CLS_JALR;
      OP_STORE: cls = CLS_STORE;
      OP_LOAD:  cls = CLS_LOAD;
      default:  cls = CLS_ILLEGAL;
    endcase
  end

  assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multi-cycle RV32I control FSM with bus watchdog and trap; RV32M_MDU_EN adds MDU sequencing
module mc_control_unit
  import ctrl_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16,
  parameter int ALU_CTRL_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instrCode,
  input  logic                  imem_ready,
  input  logic                  dmem_ready,
  input  logic                  mdu_done,
  output logic                  imem_req,
  output logic                  PCEn,
  output logic                  irEn,
  output logic                  regFileWe,
  output logic [ALU_CTRL_W-1:0] aluControl,
  output logic                  aluSrcMuxSel,
  output logic                  busWe,
  output logic                  busRe,
  output logic [2:0]            RFWDSrcMuxSel,
  output logic                  branch,
  output logic                  jal,
  output logic                  jalr,
  output logic                  is_load,
  output logic                  is_store,
  output logic                  mdu_start,
  output logic                  trap,
  output logic [1:0]            trap_cause
);

  localparam int              WD_W    = $clog2(BUS_TIMEOUT + 2);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(BUS_TIMEOUT - 1);
  localparam bit              WD_EN   = (BUS_TIMEOUT > 0);

  state_e          state_q, state_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  trap_cause_e     cause_q, cause_d;

  instr_class_e cls;
  logic [3:0]   dec_alu;
  logic         dec_illegal;
  logic [3:0]   alu4;
  logic         bus_state;
  logic         bus_ready;
  logic         wd_expired;

  ctrl_decoder u_dec (
    .instr      (instrCode),
    .cls        (cls),
    .alu_code_o (dec_alu),
    .illegal    (dec_illegal)
  );

  assign bus_state  = state_q inside {FETCH, S_MEM, L_MEM};
  assign bus_ready  = (state_q == FETCH) ? imem_ready : dmem_ready;
  assign wd_expired = WD_EN && (wdog_q == WD_LAST);

  always_comb begin
    state_d = state_q;
    wdog_d  = '0;
    cause_d = cause_q;
    case (state_q)
      FETCH:  if (imem_ready) state_d = DECODE;
      DECODE: begin
        if (dec_illegal) begin
          state_d = TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          case (cls)
            CLS_R:     state_d = R_EXE;
            CLS_I:     state_d = I_EXE;
            CLS_B:     state_d = B_EXE;
            CLS_LUI:   state_d = LU_EXE;
            CLS_AUIPC: state_d = AU_EXE;
            CLS_JAL:   state_d = J_EXE;
            CLS_JALR:  state_d = JL_EXE;
            CLS_STORE: state_d = S_EXE;
            CLS_LOAD:  state_d = L_EXE;
            CLS_MDU:   state_d = M_EXE;
            default: begin
              state_d = TRAP;
              cause_d = CAUSE_ILLEGAL;
            end
          endcase
        end
      end
      J_EXE:  state_d = J_WB;
      JL_EXE: state_d = JL_WB;
      S_EXE:  state_d = S_MEM;
      L_EXE:  state_d = L_MEM;
      S_MEM:  if (dmem_ready) state_d = FETCH;
      L_MEM:  if (dmem_ready) state_d = L_WB;
      M_EXE: begin
`ifdef RV32M_MDU_EN
        if (mdu_done) state_d = M_WB;
`else
        state_d = FETCH;
`endif
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase

    // A ready on the limit cycle completes the access instead of trapping
    if (bus_state && !bus_ready) begin
      if (wd_expired) begin
        state_d = TRAP;
        cause_d = CAUSE_TIMEOUT;
      end else begin
        wdog_d = wdog_q + WD_W'(1);
      end
    end
  end

`ifdef RV32M_MDU_EN
  logic mdu_busy_q, mdu_busy_d;
  assign mdu_busy_d = (state_q == M_EXE);
  assign mdu_start  = (state_q == M_EXE) && !mdu_busy_q;
`else
  logic unused_mdu_done;
  assign unused_mdu_done = mdu_done;
  assign mdu_start       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      wdog_q     <= '0;
      cause_q    <= CAUSE_NONE;
`ifdef RV32M_MDU_EN
      mdu_busy_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wdog_q     <= wdog_d;
      cause_q    <= cause_d;
`ifdef RV32M_MDU_EN
      mdu_busy_q <= mdu_busy_d;
`endif
    end
  end

  always_comb begin
    imem_req      = 1'b0;
    PCEn          = 1'b0;
    irEn          = 1'b0;
    regFileWe     = 1'b0;
    alu4          = ALU_ADD;
    aluSrcMuxSel  = 1'b0;
    busWe         = 1'b0;
    busRe         = 1'b0;
    RFWDSrcMuxSel = RFWD_ALU;
    branch        = 1'b0;
    jal           = 1'b0;
    jalr          = 1'b0;
    is_load       = 1'b0;
    is_store      = 1'b0;
    trap          = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        // The fetch handshake must not move PC/IR while reset is held
        PCEn     = imem_ready & rst_n;
        irEn     = imem_ready & rst_n;
      end
      R_EXE: begin
        regFileWe = 1'b1;
        alu4      = dec_alu;
      end
      I_EXE: begin
        regFileWe    = 1'b1;
        aluSrcMuxSel = 1'b1;
        alu4         = dec_alu;
      end
      B_EXE: begin
        branch = 1'b1;
        alu4   = dec_alu;
      end
      LU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_IMM;
      end
      AU_EXE: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_PC_IMM;
      end
      J_EXE: jal = 1'b1;
      JL_EXE: begin
        jal  = 1'b1;
        jalr = 1'b1;
      end
      J_WB, JL_WB: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_PC4;
      end
      S_EXE: aluSrcMuxSel = 1'b1;
      S_MEM: begin
        aluSrcMuxSel = 1'b1;
        busWe        = 1'b1;
        is_store     = 1'b1;
      end
      L_EXE: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = RFWD_LOAD;
      end
      L_MEM: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = RFWD_LOAD;
        busRe         = 1'b1;
        is_load       = 1'b1;
      end
      L_WB: begin
        aluSrcMuxSel  = 1'b1;
        RFWDSrcMuxSel = RFWD_LOAD;
        regFileWe     = 1'b1;
        is_load       = 1'b1;
      end
      M_WB: begin
        regFileWe     = 1'b1;
        RFWDSrcMuxSel = RFWD_MDU;
      end
      TRAP:    trap = 1'b1;
      default: ;
    endcase
  end

  assign aluControl = ALU_CTRL_W'(alu4);
  assign trap_cause = cause_q;

endmodule
